// File: rtl/round_pipe_if.sv
// Handshake bus for the round_pipe rounding stage: input beat side and result side.
// The DUT uses the slave modport and the beat source/sink uses master.
interface round_pipe_if #(
    parameter int EW = 8,
    parameter int MW = 50,
    parameter int FW = 23
);
    logic          in_valid;
    logic          in_ready;
    logic          in_op;
    logic [1:0]    in_rm;
    logic          in_s;
    logic [EW-1:0] in_e;
    logic [MW-1:0] in_m;
    logic          out_valid;
    logic          out_ready;
    logic          out_op;
    logic          out_s;
    logic [EW-1:0] out_e;
    logic [FW-1:0] out_m;
    logic          out_inexact;
    logic          out_ovf;

    modport master (
        output in_valid, in_op, in_rm, in_s, in_e, in_m, out_ready,
        input  in_ready, out_valid, out_op, out_s, out_e, out_m, out_inexact, out_ovf
    );

    modport slave (
        input  in_valid, in_op, in_rm, in_s, in_e, in_m, out_ready,
        output in_ready, out_valid, out_op, out_s, out_e, out_m, out_inexact, out_ovf
    );
endinterface

// File: rtl/round_pipe.sv
// Two-register IEEE-754 rounding stage (half/single, four rounding modes) with
// valid/ready handshake and a saturating counter of delivered inexact results.
module round_pipe #(
    parameter int EW    = 8,
    parameter int MW    = 50,
    parameter int FW_H  = 10,
    parameter int LSB_H = 10,
    parameter int FW_S  = 23,
    parameter int LSB_S = 23,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    round_pipe_if.slave      bus,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] inexact_cnt
);
    localparam int EH = 5;

    logic [FW_S-1:0] frac_s;
    logic            g_s;
    logic            st_s;
    logic [EW-1:0]   e_s;
    logic            at_max_s;
    logic            rnd_s;
    logic            inc_s;

    logic            s1_valid_r;
    logic            s1_op_r;
    logic            s1_s_r;
    logic [EW-1:0]   s1_e_r;
    logic [FW_S-1:0] s1_frac_r;
    logic            s1_inc_r;
    logic            s1_inexact_r;

    logic [FW_S:0]   sum_s;
    logic            carry_s;
    logic [EW:0]     e_next_s;
    logic [EW:0]     emax_s;
    logic [FW_S-1:0] m_next_s;
    logic            ovf_s;
    logic            s2_adv_s;

    logic            out_valid_r;
    logic            out_op_r;
    logic            out_s_r;
    logic [EW-1:0]   out_e_r;
    logic [FW_S-1:0] out_m_r;
    logic            out_inexact_r;
    logic            out_ovf_r;
    logic [CNT_W-1:0] cnt_r;

    logic            unused_hidden_s;
    assign unused_hidden_s = ^bus.in_m[MW-1:LSB_S+FW_S];

    // Extract fraction, guard and sticky for the beat's format; half exponent uses its low bits only.
    always_comb begin
        if (bus.in_op) begin
            frac_s   = bus.in_m[LSB_S +: FW_S];
            g_s      = bus.in_m[LSB_S-1];
            st_s     = |bus.in_m[LSB_S-2:0];
            e_s      = bus.in_e;
            at_max_s = &bus.in_e;
        end else begin
            frac_s   = {{(FW_S-FW_H){1'b0}}, bus.in_m[LSB_H +: FW_H]};
            g_s      = bus.in_m[LSB_H-1];
            st_s     = |bus.in_m[LSB_H-2:0];
            e_s      = {{(EW-EH){1'b0}}, bus.in_e[EH-1:0]};
            at_max_s = &bus.in_e[EH-1:0];
        end
    end

    // Increment decision per rounding mode.
    always_comb begin
        rnd_s = 1'b0;
        case (bus.in_rm)
            2'b00:   rnd_s = g_s & (st_s | frac_s[0]);
            2'b01:   rnd_s = 1'b0;
            2'b10:   rnd_s = ~bus.in_s & (g_s | st_s);
            2'b11:   rnd_s = bus.in_s & (g_s | st_s);
            default: rnd_s = 1'b0;
        endcase
    end

    // inf/NaN inputs are never rounded, which also keeps the exponent add from wrapping.
    assign inc_s        = rnd_s & ~at_max_s;
    assign s2_adv_s     = ~out_valid_r | bus.out_ready;
    assign bus.in_ready = ~s1_valid_r | s2_adv_s;

    // Stage 1: capture the beat and its rounding decision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r   <= 1'b0;
            s1_op_r      <= 1'b0;
            s1_s_r       <= 1'b0;
            s1_e_r       <= {EW{1'b0}};
            s1_frac_r    <= {FW_S{1'b0}};
            s1_inc_r     <= 1'b0;
            s1_inexact_r <= 1'b0;
        end else if (bus.in_ready) begin
            s1_valid_r <= bus.in_valid;
            if (bus.in_valid) begin
                s1_op_r      <= bus.in_op;
                s1_s_r       <= bus.in_s;
                s1_e_r       <= e_s;
                s1_frac_r    <= frac_s;
                s1_inc_r     <= inc_s;
                s1_inexact_r <= g_s | st_s;
            end
        end
    end

    // Apply the increment; a carry out of the fraction bumps the exponent.
    always_comb begin
        sum_s    = {1'b0, s1_frac_r} + {{FW_S{1'b0}}, s1_inc_r};
        carry_s  = s1_op_r ? sum_s[FW_S] : sum_s[FW_H];
        e_next_s = {1'b0, s1_e_r} + {{EW{1'b0}}, carry_s};
        emax_s   = s1_op_r ? {1'b0, {EW{1'b1}}} : {{(EW+1-EH){1'b0}}, {EH{1'b1}}};
        ovf_s    = carry_s & (e_next_s == emax_s);
        if (carry_s) begin
            m_next_s = {FW_S{1'b0}};
        end else if (s1_op_r) begin
            m_next_s = sum_s[FW_S-1:0];
        end else begin
            m_next_s = {{(FW_S-FW_H){1'b0}}, sum_s[FW_H-1:0]};
        end
    end

    // Stage 2: output register, held while the sink stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r   <= 1'b0;
            out_op_r      <= 1'b0;
            out_s_r       <= 1'b0;
            out_e_r       <= {EW{1'b0}};
            out_m_r       <= {FW_S{1'b0}};
            out_inexact_r <= 1'b0;
            out_ovf_r     <= 1'b0;
        end else if (s2_adv_s) begin
            out_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                out_op_r      <= s1_op_r;
                out_s_r       <= s1_s_r;
                out_e_r       <= e_next_s[EW-1:0];
                out_m_r       <= m_next_s;
                out_inexact_r <= s1_inexact_r;
                out_ovf_r     <= ovf_s;
            end
        end
    end

    // Saturating count of inexact results handed downstream; clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (cnt_clr) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (out_valid_r & bus.out_ready & out_inexact_r & ~(&cnt_r)) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign bus.out_valid   = out_valid_r;
    assign bus.out_op      = out_op_r;
    assign bus.out_s       = out_s_r;
    assign bus.out_e       = out_e_r;
    assign bus.out_m       = out_m_r;
    assign bus.out_inexact = out_inexact_r;
    assign bus.out_ovf     = out_ovf_r;
    assign inexact_cnt     = cnt_r;
endmodule

// File: tb/tb_round_pipe.sv
// Randomized + directed self-checking bench for round_pipe against an arithmetic
// rounding model; a second instance with a 2-bit counter checks saturation.
module tb_round_pipe;
    localparam int EW = 8;
    localparam int MW = 50;
    localparam int FW = 23;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cnt_clr = 1'b0;
    logic [15:0] cnt;
    logic [1:0]  cnt2;

    round_pipe_if #(.EW(EW), .MW(MW), .FW(FW)) bus ();
    round_pipe_if #(.EW(EW), .MW(MW), .FW(FW)) bus2 ();

    round_pipe dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave), .cnt_clr(cnt_clr), .inexact_cnt(cnt));
    round_pipe #(.CNT_W(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.slave), .cnt_clr(cnt_clr), .inexact_cnt(cnt2));

    assign bus2.in_valid  = bus.in_valid;
    assign bus2.in_op     = bus.in_op;
    assign bus2.in_rm     = bus.in_rm;
    assign bus2.in_s      = bus.in_s;
    assign bus2.in_e      = bus.in_e;
    assign bus2.in_m      = bus.in_m;
    assign bus2.out_ready = bus.out_ready;

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail = 0;
    logic [34:0] exp_q[$];
    int          model_cnt = 0;
    int          model_cnt2 = 0;
    logic        last_hs_in = 1'b0;
    logic        held_v = 1'b0;
    logic [34:0] held_vec;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Rounding rules in plain integer arithmetic; result {op,s,e,m,inexact,ovf}.
    function automatic logic [34:0] ref_round(input logic op, input logic [1:0] rm, input logic s,
                                              input logic [7:0] e, input logic [49:0] m);
        longint unsigned mm, frac, ee, emax, r, inc;
        int fw, lsb;
        logic g, st, ovf;
        mm   = 64'(m);
        fw   = op ? 23 : 10;
        lsb  = op ? 23 : 10;
        emax = op ? 255 : 31;
        frac = (mm >> lsb) & ((64'd1 << fw) - 1);
        g    = ((mm >> (lsb - 1)) & 64'd1) != 0;
        st   = (mm & ((64'd1 << (lsb - 1)) - 1)) != 0;
        ee   = op ? 64'(e) : 64'(e) % 32;
        case (rm)
            2'd0:    inc = (g && (st || (frac % 2 == 1))) ? 1 : 0;
            2'd1:    inc = 0;
            2'd2:    inc = (!s && (g || st)) ? 1 : 0;
            default: inc = (s && (g || st)) ? 1 : 0;
        endcase
        if (ee == emax) inc = 0;
        r   = frac + inc;
        ovf = 1'b0;
        if (r == (64'd1 << fw)) begin
            r   = 0;
            ee  = ee + 1;
            ovf = (ee == emax);
        end
        return {op, s, ee[7:0], r[22:0], g | st, ovf};
    endfunction

    function automatic logic [34:0] dut_vec();
        return {bus.out_op, bus.out_s, bus.out_e, bus.out_m, bus.out_inexact, bus.out_ovf};
    endfunction

    // One clock: monitor at the falling edge, return 1 time unit after the rising edge.
    task automatic step();
        logic [34:0] e;
        logic        hs_in, hs_out, ix;
        @(negedge clk);
        if (rst_n) begin
            chk("cnt", 64'(cnt), 64'(model_cnt));
            chk("cnt_sat2", 64'(cnt2), 64'(model_cnt2));
            if (held_v && bus.out_valid) chk("stall_stable", 64'(dut_vec()), 64'(held_vec));
            held_v   = bus.out_valid && !bus.out_ready;
            held_vec = dut_vec();
            hs_in  = bus.in_valid && bus.in_ready;
            hs_out = bus.out_valid && bus.out_ready;
            ix     = 1'b0;
            if (hs_out) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out", 64'(exp_q.size()), 64'd1);
                end else begin
                    e  = exp_q.pop_front();
                    ix = e[1];
                    chk("result", 64'(dut_vec()), 64'(e));
                end
            end
            if (cnt_clr) begin
                model_cnt  = 0;
                model_cnt2 = 0;
            end else if (hs_out && ix) begin
                model_cnt  = model_cnt + 1;
                model_cnt2 = (model_cnt2 < 3) ? model_cnt2 + 1 : 3;
            end
            if (hs_in) exp_q.push_back(ref_round(bus.in_op, bus.in_rm, bus.in_s, bus.in_e, bus.in_m));
            last_hs_in = hs_in;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input logic op, input logic [1:0] rm, input logic s,
                            input logic [7:0] e, input logic [49:0] m);
        bus.in_valid = 1'b1;
        bus.in_op = op;
        bus.in_rm = rm;
        bus.in_s  = s;
        bus.in_e  = e;
        bus.in_m  = m;
    endtask

    task automatic send_beat(input logic op, input logic [1:0] rm, input logic s,
                             input logic [7:0] e, input logic [49:0] m);
        int n;
        set_beat(op, rm, s, e, m);
        n = 0;
        do begin
            step();
            n++;
        end while (!last_hs_in && n < 50);
        if (!last_hs_in) chk("accept_timeout", 64'd0, 64'd1);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            step();
            n++;
        end
        chk("drain", 64'(exp_q.size()), 64'd0);
    endtask

    // Directed beat: fixed expected output fields and 2-cycle latency.
    task automatic run_one(input string tag, input logic op, input logic [1:0] rm, input logic s,
                           input logic [7:0] e, input logic [49:0] m,
                           input logic [7:0] xe, input logic [22:0] xm, input logic xi, input logic xo);
        int n;
        bus.out_ready = 1'b1;
        send_beat(op, rm, s, e, m);
        n = 0;
        while (!bus.out_valid && n < 10) begin
            step();
            n++;
        end
        chk({tag, "_lat"}, 64'(n), 64'd1);
        chk({tag, "_e"}, 64'(bus.out_e), 64'(xe));
        chk({tag, "_m"}, 64'(bus.out_m), 64'(xm));
        chk({tag, "_flags"}, 64'({bus.out_inexact, bus.out_ovf}), 64'({xi, xo}));
        step();
    endtask

    initial begin
        logic [63:0] r64;
        logic [49:0] m;
        logic        op;
        logic [7:0]  e;
        bus.in_valid = 1'b0; bus.in_op = 1'b0; bus.in_rm = 2'd0; bus.in_s = 1'b0;
        bus.in_e = 8'd0; bus.in_m = 50'd0; bus.out_ready = 1'b1;
        #3;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_data", 64'({bus.out_e, bus.out_m, cnt}), 64'd0);
        #9 rst_n = 1'b1;
        @(posedge clk); #1;

        run_one("rne_carry", 1'b1, 2'b00, 1'b0, 8'h7F, 50'h3FFFFFC00000, 8'h80, 23'h0, 1'b1, 1'b0);
        run_one("tie_rne", 1'b0, 2'b00, 1'b0, 8'h0F, 50'h80200, 8'h0F, 23'h200, 1'b1, 1'b0);
        run_one("tie_rup", 1'b0, 2'b10, 1'b0, 8'h0F, 50'h80200, 8'h0F, 23'h201, 1'b1, 1'b0);
        run_one("tie_rup_neg", 1'b0, 2'b10, 1'b1, 8'h0F, 50'h80200, 8'h0F, 23'h200, 1'b1, 1'b0);
        run_one("tie_rdn_neg", 1'b0, 2'b11, 1'b1, 8'h0F, 50'h80200, 8'h0F, 23'h201, 1'b1, 1'b0);
        run_one("ovf_rne", 1'b1, 2'b00, 1'b0, 8'hFE, 50'h3FFFFFC00000, 8'hFF, 23'h0, 1'b1, 1'b1);
        run_one("ovf_rtz", 1'b1, 2'b01, 1'b0, 8'hFE, 50'h3FFFFFC00000, 8'hFE, 23'h7FFFFF, 1'b1, 1'b0);
        run_one("inf_pass", 1'b1, 2'b00, 1'b0, 8'hFF, 50'h3FFFFFC00000, 8'hFF, 23'h7FFFFF, 1'b1, 1'b0);

        // Counter: clear, then 5 inexact and 3 exact beats.
        cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
        for (int i = 0; i < 8; i++) send_beat(1'b0, 2'b01, 1'b0, 8'h0F, (i % 8 < 5) ? 50'h80200 : 50'h80000);
        drain(); step();
        chk("cnt5", 64'(cnt), 64'd5);
        chk("cnt_sat", 64'(cnt2), 64'd3);
        // Clear coinciding with an inexact handshake.
        bus.out_ready = 1'b0;
        send_beat(1'b0, 2'b01, 1'b0, 8'h0F, 50'h80200);
        step();
        bus.out_ready = 1'b1; cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        step();
        chk("clr_prio", 64'(cnt), 64'd0);

        // Backpressure: 4 back-to-back beats with a 3-cycle stall.
        bus.out_ready = 1'b0;
        send_beat(1'b1, 2'b00, 1'b0, 8'h10, 50'h3FFFFFC00000);
        send_beat(1'b0, 2'b10, 1'b0, 8'h1E, 50'h000FFE01);
        chk("bp_ready_low", 64'(bus.in_ready), 64'd0);
        set_beat(1'b1, 2'b11, 1'b1, 8'h20, 50'h12345678ABC);
        step();
        chk("bp_hold", 64'(last_hs_in), 64'd0);
        bus.out_ready = 1'b1;
        send_beat(1'b1, 2'b11, 1'b1, 8'h20, 50'h12345678ABC);
        send_beat(1'b0, 2'b00, 1'b1, 8'h05, 50'h3FFFF);
        drain();

        // Randomized traffic with random stalls and occasional counter clears.
        for (int i = 0; i < 600; i++) begin
            if (!bus.in_valid || last_hs_in) begin
                r64 = {$urandom(), $urandom()};
                m   = r64[49:0];
                op  = $urandom_range(0, 1) == 1;
                case ($urandom_range(0, 4))
                    0: e = op ? 8'hFE : 8'h1E;
                    1: e = 8'hFF;
                    default: e = 8'($urandom_range(0, 255));
                endcase
                if ($urandom_range(0, 3) == 0) begin
                    if (op) m[45:23] = '1; else m[19:10] = '1;
                end
                if ($urandom_range(0, 3) == 0) begin
                    if (op) m[22:0] = '0; else m[9:0] = '0;
                end
                set_beat(op, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), e, m);
                bus.in_valid = $urandom_range(0, 3) != 0;
            end
            bus.out_ready = $urandom_range(0, 9) < 7;
            cnt_clr = $urandom_range(0, 31) == 0;
            step();
        end
        cnt_clr = 1'b0;
        drain();

        // Reset with two beats in flight.
        bus.out_ready = 1'b0;
        send_beat(1'b1, 2'b00, 1'b0, 8'h40, 50'h3FFFFFC00000);
        send_beat(1'b0, 2'b00, 1'b0, 8'h0A, 50'h80200);
        chk("pipe_full", 64'({bus.out_valid, bus.in_ready}), 64'b10);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
        exp_q.delete();
        model_cnt = 0; model_cnt2 = 0; held_v = 1'b0;
        #4 rst_n = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) begin
            chk("post_rst_no_out", 64'(bus.out_valid), 64'd0);
            step();
        end
        chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/round_pipe.md
# round_pipe

Pipelined, parametrised IEEE-754 rounding stage for the floating-point MAC datapath. It sits between the normalise stage and the result packer. It accepts a normalised sign/exponent/extended mantissa for half (op=0) or single (op=1) precision and applies one of four run-time rounding modes. It produces the rounded fraction, exponent with carry and overflow handling, and inexact/overflow flags. The stage is two registers deep with a valid/ready handshake and a saturating inexact-event counter.

## Interface
- EW, 8, exponent field width carried on the bus; half uses the low 5 bits.
- MW, 50, input extended-mantissa width.
- FW_H, 10, half fraction width.
- LSB_H, 10, bit index of the half fraction LSB in in_m.
- FW_S, 23, single fraction width.
- LSB_S, 23, bit index of the single fraction LSB in in_m.
- CNT_W, 16, inexact counter width.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  stage can accept
- in_op  in  1  0 = half, 1 = single
- in_rm  in  2  00 RNE, 01 RTZ, 10 RUP (+inf), 11 RDN (-inf)
- in_s  in  1  sign
- in_e  in  EW  biased exponent
- in_m  in  MW  normalised mantissa; fraction, guard and sticky bits below the hidden bit
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- out_op  out  1  forwarded op
- out_s  out  1  forwarded sign
- out_e  out  EW  rounded exponent; upper bits zero for half
- out_m  out  FW_S  rounded fraction; half result in [FW_H-1:0], upper bits zero
- out_inexact  out  1  guard or sticky set
- out_ovf  out  1  rounding carried the exponent to all-ones
- cnt_clr  in  1  synchronous clear of inexact counter
- inexact_cnt  out  CNT_W  saturating count of inexact results delivered

## Operation
- Per op, let FW and LSB be the format's fraction width and LSB index, and EMAX the all-ones exponent (31 for half, 255 for single).
  - frac = in_m[LSB+FW-1:LSB]
  - g = in_m[LSB-1]
  - st = |in_m[LSB-2:0]
- Increment decision inc:
  - RNE: g & (st | frac[0])
  - RTZ: 0
  - RUP: ~s & (g | st)
  - RDN: s & (g | st)
- Stage 1 registers op, s, e, frac, inc, and inexact = g|st.
- Stage 2 computes sum = {1'b0, frac} + inc, which is FW+1 bits wide.
  - If sum[FW] = 1, the fraction is 0 and the exponent is e+1.
  - Otherwise the fraction is sum[FW-1:0] and the exponent is e.
- Overflow: if the resulting exponent equals EMAX, out_ovf = 1 and out_m = 0, so the result is infinity.
  - An input already at EMAX passes through unchanged with ovf = 0, since inf/NaN is not rounded.
- The exponent add is performed in EW+1 bits and no wrap is permitted. The format clamp above prevents it.
- inexact_cnt increments by 1 on each output handshake (out_valid & out_ready) with out_inexact = 1.
  - It saturates at 2^CNT_W-1.
  - cnt_clr has priority: clear and increment in the same cycle gives 0.
- Mode, op and rm are captured per beat. Beats of differing formats and modes may be interleaved freely.

## Timing
- Latency is 2 cycles from input handshake to out_valid, with no bubbles at full throughput (1 beat/cycle while out_ready = 1).
- Stall rules:
  - Stage 2 holds while out_valid & ~out_ready.
  - Stage 1 advances when stage 2 is empty or advancing.
  - in_ready = ~s1_valid | s1_advance.
  - in_ready is combinational from out_ready. No other combinational in-to-out path exists.
- Outputs are stable while out_valid & ~out_ready.
- Reset (asynchronous, rst_n low):
  - Both valids are 0 and in_ready = 1 one gate after release.
  - out_* data fields are 0 and inexact_cnt is 0.
  - In-flight beats are discarded with no output.
- in_valid with in_ready = 0 is ignored. The source must hold its data.

## Test plan
- Single RNE carry: op=1, rm=00, e=0x7F, m=0x3FFFFFC00000 (frac all ones, g=1) -> two cycles later out_e=0x80, out_m=0, out_inexact=1, out_ovf=0.
- Half ties: op=0, m=0x80200 (frac 0x200, g=1, st=0), s=0, e=0x0F:
  - rm=00 -> out_m=0x200
  - rm=10 -> 0x201
  - rm=10 with s=1 -> 0x200
  - rm=11 with s=1 -> 0x201
- Overflow:
  - op=1, e=0xFE, m=0x3FFFFFC00000, rm=00 -> out_e=0xFF, out_m=0, out_ovf=1.
  - Same beat with rm=01 -> out_e=0xFE, out_m=0x7FFFFF, ovf=0.
- Backpressure: 4 back-to-back beats, out_ready=0 for 3 cycles:
  - in_ready drops once 2 beats are held.
  - All 4 results emerge in order, unchanged, with no duplicates.
- Counter: 5 inexact and 3 exact beats -> inexact_cnt=5.
  - cnt_clr coinciding with an inexact handshake -> 0.
  - With CNT_W=2, the count saturates at 3.
- Reset mid-flight: rst_n low with 2 beats in the pipe -> out_valid=0 immediately, no result after release, in_ready=1.
